ipm2l_hsstlp_lane_rst_sched: RTL and testbench

Schedules HSSTLP lane power-up/reset sequences on a quad whose lanes share one PLL. Sits above the PLL reset FSM: holds lanes off until the PLL reports done, grants lane reset requests one at a time (round-robin), times each lane's power-down release and reset pulse, and waits for lane ready. On a filtered PLL lock loss it re-initialises the PLL FSM and re-sequences every lane.

---
 rtl/ipm2l_hsstlp_rst_pkg.sv | 35 +++
 rtl/ipm2l_hsstlp_rr_arb.sv | 36 +++
 rtl/ipm2l_hsstlp_lane_rst_sched.sv | 172 +++++++++++++++++
 tb/tb_ipm2l_hsstlp_lane_rst_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipm2l_hsstlp_rst_pkg.sv
// Shared definitions for the HSSTLP reset sequencers.
//   - state encodings of the lane reset scheduler (3 bits)
//   - counter width and fixed filter/hold lengths
//   - timer derivation from the free-running clock frequency (MHz), so
//     the PLL reset FSM and the lane scheduler use identical timings
package ipm2l_hsstlp_rst_pkg;

    localparam int CNTR_WIDTH = 16;

    localparam logic [2:0] ST_WAIT_PLL = 3'd0;
    localparam logic [2:0] ST_ARB      = 3'd1;
    localparam logic [2:0] ST_PD_REL   = 3'd2;
    localparam logic [2:0] ST_RST_HOLD = 3'd3;
    localparam logic [2:0] ST_WAIT_RDY = 3'd4;
    localparam logic [2:0] ST_REINIT   = 3'd5;

    localparam logic [3:0]            LOCK_FILT = 4'd8;
    localparam logic [CNTR_WIDTH-1:0] T_REINIT  = 16'd16;

    // Power-down hold: 2 x 1 us.
    function automatic logic [CNTR_WIDTH-1:0] t_pd_cycles(input int freq);
        return CNTR_WIDTH'(2 * freq);
    endfunction

    // Reset pulse: 2 x 0.5 us.
    function automatic logic [CNTR_WIDTH-1:0] t_rst_cycles(input int freq);
        return CNTR_WIDTH'(2 * (freq / 2));
    endfunction

    // Lane ready timeout: 2 x 50 us.
    function automatic logic [CNTR_WIDTH-1:0] t_to_cycles(input int freq);
        return CNTR_WIDTH'(2 * (50 * freq));
    endfunction

endpackage

// File: rtl/ipm2l_hsstlp_rr_arb.sv
// Combinational round-robin pick.
//   req  : request bits, one per lane
//   ptr  : lane with highest priority this pick
//   gnt  : index of the first set request at or after ptr (wrapping at N)
//   vld  : any request set
module ipm2l_hsstlp_rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt,
    output logic             vld
);

    logic [2*N-1:0] dbl;
    logic [IDX_W:0] sum;

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        sum = '0;
        // Rotate so that bit 0 is the lane at ptr, then a plain priority pick.
        dbl = {req, req} >> ptr;
        for (int i = 0; i < N; i++) begin
            if (!vld && dbl[i]) begin
                vld = 1'b1;
                sum = {1'b0, ptr} + (IDX_W+1)'(i);
                if (sum >= (IDX_W+1)'(N))
                    sum = sum - (IDX_W+1)'(N);
                gnt = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ipm2l_hsstlp_lane_rst_sched.sv
// Lane power-up/reset scheduler for a quad sharing one PLL.
// Waits for the PLL reset FSM, then sequences one lane at a time
// (round-robin): power-down release, reset release, wait for ready.
// A filtered lock loss (or i_pll_done dropping) restarts the PLL FSM
// and re-sequences every lane.
//   clk, rst_n       : free-running clock, async active-low reset
//   i_pll_done       : PLL reset FSM done
//   pll_lock         : raw PLL lock
//   i_lane_req       : per-lane reset request (level, sampled in ARB)
//   i_lane_ready     : per-lane ready from HSST
//   o_pll_fsm_rst_n  : active-low reset to the PLL reset FSM
//   P_LANE_PD        : lane power-down (1 = powered down)
//   P_LANE_RST       : lane reset (1 = in reset)
//   o_lane_done      : lane sequenced and ready
//   o_lane_err       : sticky ready-timeout flag
module ipm2l_hsstlp_lane_rst_sched
    import ipm2l_hsstlp_rst_pkg::*;
#(
    parameter int FREE_CLOCK_FREQ = 100,
    parameter int LANE_NUM        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_pll_done,
    input  logic                pll_lock,
    input  logic [LANE_NUM-1:0] i_lane_req,
    input  logic [LANE_NUM-1:0] i_lane_ready,
    output logic                o_pll_fsm_rst_n,
    output logic [LANE_NUM-1:0] P_LANE_PD,
    output logic [LANE_NUM-1:0] P_LANE_RST,
    output logic [LANE_NUM-1:0] o_lane_done,
    output logic [LANE_NUM-1:0] o_lane_err
);

    localparam int IDX_W = (LANE_NUM > 1) ? $clog2(LANE_NUM) : 1;
    localparam logic [CNTR_WIDTH-1:0] T_PD  = t_pd_cycles(FREE_CLOCK_FREQ);
    localparam logic [CNTR_WIDTH-1:0] T_RST = t_rst_cycles(FREE_CLOCK_FREQ);
    localparam logic [CNTR_WIDTH-1:0] T_TO  = t_to_cycles(FREE_CLOCK_FREQ);

    logic [2:0]            state;
    logic [CNTR_WIDTH-1:0] cnt;
    logic [3:0]            filt;
    logic [LANE_NUM-1:0]   pend;
    logic [LANE_NUM-1:0]   lane_oh;   // lane currently being sequenced
    logic [LANE_NUM-1:0]   req_all;
    logic [LANE_NUM-1:0]   gnt_oh;
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      gnt;
    logic [IDX_W-1:0]      ptr_nxt;
    logic                  gnt_vld;
    logic                  mon;
    logic                  lock_lost;

    assign req_all = pend | i_lane_req;
    assign gnt_oh  = LANE_NUM'(1) << gnt;
    assign ptr_nxt = (gnt == IDX_W'(LANE_NUM - 1)) ? '0 : gnt + IDX_W'(1);

    // Lock supervision only once the PLL FSM has finished and is not
    // being restarted; done dropping is treated exactly like lock loss.
    assign mon       = (state != ST_WAIT_PLL) && (state != ST_REINIT);
    assign lock_lost = mon && ((filt == LOCK_FILT) || !i_pll_done);

    ipm2l_hsstlp_rr_arb #(.N(LANE_NUM), .IDX_W(IDX_W)) u_arb (
        .req (req_all),
        .ptr (ptr),
        .gnt (gnt),
        .vld (gnt_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_WAIT_PLL;
            cnt             <= '0;
            filt            <= '0;
            pend            <= '1;
            lane_oh         <= '0;
            ptr             <= '0;
            o_pll_fsm_rst_n <= 1'b1;
            P_LANE_PD       <= '1;
            P_LANE_RST      <= '1;
            o_lane_done     <= '0;
            o_lane_err      <= '0;
        end else begin
            // Consecutive lock-low cycles; saturates at the threshold.
            if (!mon || pll_lock)
                filt <= '0;
            else if (i_pll_done && filt != LOCK_FILT)
                filt <= filt + 4'd1;

            if (lock_lost) begin
                // In-flight lane is abandoned; no error is flagged.
                state           <= ST_REINIT;
                cnt             <= '0;
                o_pll_fsm_rst_n <= 1'b0;
                P_LANE_PD       <= '1;
                P_LANE_RST      <= '1;
                o_lane_done     <= '0;
                pend            <= '1;
            end else begin
                case (state)
                    ST_WAIT_PLL: begin
                        if (i_pll_done) begin
                            state <= ST_ARB;
                            cnt   <= '0;
                        end
                    end
                    ST_ARB: begin
                        if (gnt_vld) begin
                            pend        <= req_all & ~gnt_oh;
                            o_lane_done <= o_lane_done & ~gnt_oh;
                            P_LANE_PD   <= P_LANE_PD | gnt_oh;
                            P_LANE_RST  <= P_LANE_RST | gnt_oh;
                            lane_oh     <= gnt_oh;
                            ptr         <= ptr_nxt;
                            state       <= ST_PD_REL;
                            cnt         <= '0;
                        end else begin
                            pend <= req_all;
                        end
                    end
                    ST_PD_REL: begin
                        // Counts 0..T_PD: release lands T_PD+1 cycles after grant.
                        if (cnt == T_PD) begin
                            P_LANE_PD <= P_LANE_PD & ~lane_oh;
                            state     <= ST_RST_HOLD;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_RST_HOLD: begin
                        if (cnt == T_RST - 1'b1) begin
                            P_LANE_RST <= P_LANE_RST & ~lane_oh;
                            state      <= ST_WAIT_RDY;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_WAIT_RDY: begin
                        if (|(i_lane_ready & lane_oh)) begin
                            o_lane_done <= o_lane_done | lane_oh;
                            state       <= ST_ARB;
                            cnt         <= '0;
                        end else if (cnt == T_TO - 1'b1) begin
                            o_lane_err <= o_lane_err | lane_oh;
                            pend       <= pend | lane_oh;
                            state      <= ST_ARB;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_REINIT: begin
                        if (cnt == T_REINIT - 1'b1) begin
                            o_pll_fsm_rst_n <= 1'b1;
                            state           <= ST_WAIT_PLL;
                            cnt             <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_WAIT_PLL;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ipm2l_hsstlp_lane_rst_sched.sv
module tb_ipm2l_hsstlp_lane_rst_sched;

    localparam int NL        = 4;
    localparam int T_PD      = 200;
    localparam int T_RST     = 100;
    localparam int T_TO      = 10000;
    localparam int LOCK_FILT = 8;
    localparam int T_REINIT  = 16;

    localparam int PH_WAIT = 0, PH_ARB = 1, PH_SEQ = 2, PH_REINIT = 3;

    logic          clk;
    logic          rst_n;
    logic          i_pll_done;
    logic          pll_lock;
    logic [NL-1:0] i_lane_req;
    logic [NL-1:0] i_lane_ready;
    logic          o_pll_fsm_rst_n;
    logic [NL-1:0] P_LANE_PD;
    logic [NL-1:0] P_LANE_RST;
    logic [NL-1:0] o_lane_done;
    logic [NL-1:0] o_lane_err;

    int tests = 0;
    int fails = 0;

    ipm2l_hsstlp_lane_rst_sched #(.FREE_CLOCK_FREQ(100), .LANE_NUM(NL)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_pll_done      (i_pll_done),
        .pll_lock        (pll_lock),
        .i_lane_req      (i_lane_req),
        .i_lane_ready    (i_lane_ready),
        .o_pll_fsm_rst_n (o_pll_fsm_rst_n),
        .P_LANE_PD       (P_LANE_PD),
        .P_LANE_RST      (P_LANE_RST),
        .o_lane_done     (o_lane_done),
        .o_lane_err      (o_lane_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Sequencing is tracked by elapsed cycles since grant rather than by
    // sub-states: PD release at +T_PD+1, RST release T_RST later, then
    // ready is watched for up to T_TO cycles.
    int       m_cyc, m_phase, m_t, m_low;
    bit [1:0] m_ptr, m_lane;
    bit [3:0] m_pend, e_pd, e_rst, e_done, e_err;
    bit       e_prst;

    task automatic mreset();
        m_cyc = 0; m_phase = PH_WAIT; m_t = 0; m_low = 0;
        m_ptr = 2'd0; m_lane = 2'd0; m_pend = 4'hF;
        e_pd = 4'hF; e_rst = 4'hF; e_done = 4'h0; e_err = 4'h0; e_prst = 1'b1;
    endtask

    task automatic mstep();
        int  k;
        bit  found;
        bit [1:0] g, l;
        found = 1'b0; g = 2'd0;
        m_cyc++;
        case (m_phase)
            PH_WAIT: begin
                m_low = 0;
                if (i_pll_done) begin m_phase = PH_ARB; m_t = m_cyc; end
            end
            PH_REINIT: begin
                m_low = 0;
                if (m_cyc - m_t == T_REINIT) begin e_prst = 1'b1; m_phase = PH_WAIT; end
            end
            default: begin
                if (!i_pll_done || m_low >= LOCK_FILT) begin
                    m_phase = PH_REINIT; m_t = m_cyc; m_low = 0;
                    e_prst = 1'b0; e_pd = 4'hF; e_rst = 4'hF; e_done = 4'h0; m_pend = 4'hF;
                end else begin
                    m_low = pll_lock ? 0 : m_low + 1;
                    if (m_phase == PH_ARB) begin
                        m_pend = m_pend | i_lane_req;
                        for (int i = 0; i < NL; i++) begin
                            l = m_ptr + 2'(i);
                            if (!found && m_pend[l]) begin found = 1'b1; g = l; end
                        end
                        if (found) begin
                            m_pend[g] = 1'b0; e_done[g] = 1'b0; e_pd[g] = 1'b1; e_rst[g] = 1'b1;
                            m_ptr = g + 2'd1; m_lane = g; m_phase = PH_SEQ; m_t = m_cyc;
                        end
                    end else begin
                        k = m_cyc - m_t;
                        if (k == T_PD + 1) e_pd[m_lane] = 1'b0;
                        if (k == T_PD + 1 + T_RST) e_rst[m_lane] = 1'b0;
                        if (k > T_PD + 1 + T_RST) begin
                            if (i_lane_ready[m_lane]) begin
                                e_done[m_lane] = 1'b1; m_phase = PH_ARB;
                            end else if (k - (T_PD + 1 + T_RST) == T_TO) begin
                                e_err[m_lane] = 1'b1; m_pend[m_lane] = 1'b1; m_phase = PH_ARB;
                            end
                        end
                    end
                end
            end
        endcase
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) mreset();
            else mstep();
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            tests++;
            if ({o_pll_fsm_rst_n, P_LANE_PD, P_LANE_RST, o_lane_done, o_lane_err} !==
                {e_prst, e_pd, e_rst, e_done, e_err}) begin
                fails++;
                $display("FAIL cycle_cmp t=%0t got prst=%b pd=%h rst=%h done=%h err=%h, want prst=%b pd=%h rst=%h done=%h err=%h",
                         $time, o_pll_fsm_rst_n, P_LANE_PD, P_LANE_RST, o_lane_done, o_lane_err,
                         e_prst, e_pd, e_rst, e_done, e_err);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, want);
        end
    endtask

    function automatic bit probe(input int which, input logic [1:0] ln);
        case (which)
            0: return P_LANE_PD[ln] == 1'b0;
            1: return P_LANE_RST[ln] == 1'b0;
            2: return o_lane_done[ln] == 1'b1;
            3: return o_lane_done[ln] == 1'b0;
            4: return o_lane_err[ln] == 1'b1;
            5: return o_pll_fsm_rst_n == 1'b0;
            6: return o_pll_fsm_rst_n == 1'b1;
            7: return P_LANE_PD[ln] == 1'b1;
            default: return o_lane_done == 4'hF;
        endcase
    endfunction

    // Counts clock edges until the condition is seen; bounded.
    task automatic wait_for(input int which, input logic [1:0] ln, input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!probe(which, ln) && n < max);
        tests++;
        if (!probe(which, ln)) begin
            fails++;
            $display("FAIL wait_cond%0d lane%0d: not seen within %0d cycles", which, ln, max);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        rst_n = 1'b0; i_pll_done = 1'b0; pll_lock = 1'b1;
        i_lane_req = 4'h0; i_lane_ready = 4'hF;
        wait_neg(3);
        chk("rst_prst", int'(o_pll_fsm_rst_n), 1);
        chk("rst_pd",   int'(P_LANE_PD), 15);
        chk("rst_rst",  int'(P_LANE_RST), 15);
        chk("rst_done", int'(o_lane_done), 0);
        chk("rst_err",  int'(o_lane_err), 0);
        rst_n = 1'b1;
        wait_neg(45);

        // Power-up: lanes 0..3 in order, 303 cycles per lane.
        i_pll_done = 1'b1;
        wait_for(0, 2'd0, 400, n);  chk("pd0_fall", n, 203);
        wait_for(1, 2'd0, 200, n);  chk("rst0_fall", n, 100);
        wait_for(2, 2'd0, 10, n);   chk("done0_rise", n, 1);
        wait_for(2, 2'd1, 400, n);  chk("done1_rise", n, 303);
        wait_for(2, 2'd2, 400, n);  chk("done2_rise", n, 303);
        wait_for(2, 2'd3, 400, n);  chk("done3_rise", n, 303);
        chk("init_all_done", int'(o_lane_done), 15);

        // Requests on lanes 1 and 3: 1 first, then 3.
        i_lane_req = 4'b1010;
        wait_for(3, 2'd1, 10, n);   chk("req_l1_grant", n, 1);
        i_lane_req[1] = 1'b0;
        wait_for(3, 2'd3, 400, n);  chk("req_l3_grant", n, 303);
        i_lane_req[3] = 1'b0;
        wait_for(2, 2'd3, 400, n);  chk("req_l3_done", n, 302);

        // Lane 2 never ready: timeout, lane 0 served, then lane 2 again.
        i_lane_ready = 4'b1011;
        i_lane_req[2] = 1'b1;
        wait_for(3, 2'd2, 10, n);   chk("to_l2_grant", n, 1);
        i_lane_req[2] = 1'b0;
        i_lane_req[0] = 1'b1;
        wait_for(4, 2'd2, 11000, n); chk("to_l2_err", n, 10301);
        wait_for(3, 2'd0, 10, n);   chk("to_l0_grant", n, 1);
        i_lane_req[0] = 1'b0;
        wait_for(7, 2'd2, 400, n);  chk("to_l2_regrant", n, 303);
        i_lane_ready[2] = 1'b1;
        wait_for(2, 2'd2, 400, n);  chk("to_l2_done", n, 302);
        chk("to_err_sticky", int'(o_lane_err), 4);

        // Lock low 7 cycles: ignored. 8 cycles: PLL FSM restart.
        pll_lock = 1'b0;
        wait_neg(7);
        pll_lock = 1'b1;
        wait_neg(3);
        chk("lock7_no_effect", int'(o_pll_fsm_rst_n), 1);
        pll_lock = 1'b0;
        wait_for(5, 2'd0, 20, n);   chk("lock8_reinit", n, 9);
        pll_lock = 1'b1; i_pll_done = 1'b0;
        chk("reinit_done_clr", int'(o_lane_done), 0);
        wait_for(6, 2'd0, 40, n);   chk("reinit_len", n, 16);
        wait_neg(5);
        i_pll_done = 1'b1;
        wait_for(8, 2'd0, 1400, n); chk("reseq_len", n, 1213);

        // Lock loss lands on the same edge that samples lane 0 ready.
        i_lane_ready = 4'b1110;
        i_lane_req[0] = 1'b1;
        wait_for(3, 2'd0, 10, n);   chk("race_grant", n, 1);
        i_lane_req[0] = 1'b0;
        wait_for(1, 2'd0, 400, n);  chk("race_rst_fall", n, 301);
        pll_lock = 1'b0;
        wait_neg(8);
        i_lane_ready[0] = 1'b1;
        wait_neg(1);
        chk("race_prst", int'(o_pll_fsm_rst_n), 0);
        chk("race_done0", int'(o_lane_done[0]), 0);
        chk("race_err0", int'(o_lane_err[0]), 0);
        pll_lock = 1'b1; i_pll_done = 1'b0;
        wait_for(6, 2'd0, 40, n);
        wait_neg(3);
        i_pll_done = 1'b1;
        wait_for(8, 2'd0, 1400, n);

        // Async reset while lane 1 is in RST_HOLD.
        i_lane_req[1] = 1'b1;
        wait_for(3, 2'd1, 10, n);
        i_lane_req[1] = 1'b0;
        wait_for(0, 2'd1, 400, n);  chk("ar_pd1_fall", n, 201);
        wait_neg(10);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pd",   int'(P_LANE_PD), 15);
        chk("ar_rst",  int'(P_LANE_RST), 15);
        chk("ar_done", int'(o_lane_done), 0);
        chk("ar_err",  int'(o_lane_err), 0);
        chk("ar_prst", int'(o_pll_fsm_rst_n), 1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_for(8, 2'd0, 1400, n); chk("ar_reseq_len", n, 1213);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
